// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core run controller and its loader helper.
package core_ctrl_pkg;

    // Controller life-cycle states
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        DONE,
        FAULT
    } run_state_t;

    // Exit code reported when the watchdog ends a run
    localparam logic [31:0] WDOG_FAULT_CODE = 32'hDEAD_0001;

    // Clamp a requested word count to the instruction memory depth
    function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                              input int unsigned max_words);
        logic [31:0] max_w;
        max_w = 32'(max_words);
        if (32'(len) > max_w) begin
            return max_w[15:0];
        end
        return len;
    endfunction

    // States in which a new load or run may be requested
    function automatic logic is_parked(input run_state_t s);
        return (s == IDLE) || (s == DONE) || (s == FAULT);
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Assembles little-endian 32-bit words from the loader byte stream and
// produces a one-cycle word-valid pulse, dropping ld_ready during that pulse.
import core_ctrl_pkg::*;

module loader_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        more,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    output logic        ld_ready,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] partial;

    // Byte intake, shift assembly and strobe-cycle ready gating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            partial    <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
            ld_ready   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (arm) begin
                ld_ready <= 1'b1;
                byte_cnt <= 2'd0;
                partial  <= 24'd0;
            end else if (word_valid) begin
                ld_ready <= more;
            end else if (ld_ready && ld_valid) begin
                if (byte_cnt == 2'd3) begin
                    word       <= {ld_byte, partial};
                    word_valid <= 1'b1;
                    ld_ready   <= 1'b0;
                    byte_cnt   <= 2'd0;
                end else begin
                    partial  <= {ld_byte, partial[23:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/core_run_controller.sv
// Run controller for the pipelined core: loads instruction memory from the
// byte loader, holds and releases core reset, and ends a run on a halt store.
// Optional watchdog enabled by defining CORE_RUN_WATCHDOG_EN.
import core_ctrl_pkg::*;

module core_run_controller #(
    parameter int          IMEM_WORDS  = 1024,
    parameter logic [31:0] HALT_ADDR   = 32'h0000_FFFC,
    parameter int          RESET_HOLD  = 4,
    parameter logic [31:0] WDOG_CYCLES = 32'd1_000_000,
    localparam int         AW          = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    input  logic [15:0]   load_len,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    output logic          ld_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    input  logic          start,
    output logic          core_reset,
    input  logic [31:0]   data_memory_addr,
    input  logic [31:0]   data_memory_wd,
    input  logic          data_memory_we,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [31:0]   exit_code,
    output logic [31:0]   cycle_count
);

`ifdef CORE_RUN_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);

    run_state_t    state;
    logic [AW-1:0] word_idx;
    logic [15:0]   words_left;
    logic [15:0]   hold_cnt;
    logic          fault_q;

    logic [15:0]   eff_len;
    logic          arm;
    logic          word_valid;
    logic [31:0]   word;
    logic          more;
    logic          halt_hit;
    logic [31:0]   cnt_next;
    logic          wdog_hit;

    assign eff_len  = clamp_len(load_len, IMEM_WORDS);
    // A zero-length load never opens the byte port.
    assign arm      = is_parked(state) && load_req && (eff_len != 16'd0);
    assign more     = (words_left != 16'd1);
    assign halt_hit = data_memory_we && (data_memory_addr == HALT_ADDR);
    assign cnt_next = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    assign wdog_hit = WDOG_EN && (cnt_next >= WDOG_CYCLES);

    assign imem_we    = word_valid;
    assign imem_wdata = word;
    assign imem_waddr = word_idx;
    assign fault      = fault_q;

    loader_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .more       (more),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .word_valid (word_valid),
        .word       (word)
    );

    // Life-cycle FSM with its counters, halt snoop and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            core_reset  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault_q     <= 1'b0;
            exit_code   <= 32'd0;
            cycle_count <= 32'd0;
            word_idx    <= '0;
            words_left  <= 16'd0;
            hold_cnt    <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE, FAULT: begin
                    if (load_req) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fault_q    <= 1'b0;
                        exit_code  <= 32'd0;
                        word_idx   <= '0;
                        words_left <= eff_len;
                    end else if (start) begin
                        state       <= HOLD;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        fault_q     <= 1'b0;
                        exit_code   <= 32'd0;
                        cycle_count <= 32'd0;
                        hold_cnt    <= 16'd0;
                    end
                end
                LOAD: begin
                    if (words_left == 16'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (word_valid) begin
                        word_idx   <= word_idx + AW'(1);
                        words_left <= words_left - 16'd1;
                        if (words_left == 16'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                RUN: begin
                    cycle_count <= cnt_next;
                    if (halt_hit) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        core_reset <= 1'b1;
                        exit_code  <= data_memory_wd;
                    end else if (wdog_hit) begin
                        state      <= FAULT;
                        fault_q    <= 1'b1;
                        busy       <= 1'b0;
                        core_reset <= 1'b1;
                        exit_code  <= WDOG_FAULT_CODE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    core_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule
